// File: rtl/mod_counter_pkg.sv
// Shared definitions for the counter family: state encoding, direction
// constants and a value clamp usable by any counter that accepts presets.
package mod_counter_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Limit a preset to the top of the count range.
   function automatic logic [31:0] clamp_max(input logic [31:0] val,
                                             input logic [31:0] max_val);
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/wrap_tally.sv
// Saturating event tally with synchronous reset and clear.
// Only instantiated when WRAP_TALLY_EN is defined.
module wrap_tally #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   // Clear beats increment; the tally sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   // Tally register.
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/mod_counter_updown.sv
// Modulo-MODULE up/down counter with one-shot halt, clamped load and a
// direction-aware terminal count. Defining WRAP_TALLY_EN adds the WRAPS
// output, a saturating count of continuous-mode wraps.
module mod_counter_updown
   import mod_counter_pkg::*;
#(
   parameter int MODULE     = 12500000,
   parameter int WIDTH      = 24
`ifdef WRAP_TALLY_EN
  ,parameter int WRAP_WIDTH = 8
`endif
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLK_ENA,
   input  logic             LOADn,
   input  logic             UP,
   input  logic             ONESHOT,
   input  logic [WIDTH-1:0] P,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             DONE
`ifdef WRAP_TALLY_EN
  ,output logic [WRAP_WIDTH-1:0] WRAPS
`endif
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULE - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] tv;
   logic [WIDTH-1:0] q_load;
   logic             at_tv;

   // Terminal value follows the live direction input.
   assign tv     = (UP == DIR_UP) ? MAXV : '0;
   assign at_tv  = (q_q == tv);
   assign q_load = WIDTH'(clamp_max(32'(P), 32'(MODULE - 1)));

   // Next count and state: load beats enable; halted state ignores enable.
   always_comb begin
      q_d     = q_q;
      state_d = state_q;
      if (!LOADn) begin
         q_d     = q_load;
         state_d = RUN;
      end else if ((state_q == RUN) && CLK_ENA) begin
         if (!at_tv)
            q_d = (UP == DIR_DOWN) ? (q_q - WIDTH'(1)) : (q_q + WIDTH'(1));
         else if (!ONESHOT)
            q_d = (UP == DIR_DOWN) ? MAXV : '0;
         else
            state_d = HALT;
      end
   end

   // Count and state registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         q_q     <= '0;
         state_q <= RUN;
      end else begin
         q_q     <= q_d;
         state_q <= state_d;
      end
   end

   assign Q    = q_q;
   assign TC   = CLK_ENA & at_tv & (state_q == RUN);
   assign DONE = (state_q == HALT);

`ifdef WRAP_TALLY_EN
   // A wrap is a terminal-count edge in continuous mode.
   wrap_tally #(.W(WRAP_WIDTH)) u_wrap_tally (
      .clk (CLK),
      .rst (RST),
      .clr (~LOADn),
      .inc (TC & ~ONESHOT),
      .cnt (WRAPS)
   );
`endif

endmodule

// File: tb/tb_mod_counter_updown.sv
// Scoreboard bench for mod_counter_updown (MODULE=10, WIDTH=4, WRAP_WIDTH=2).
// Each vector drives inputs on the falling edge and queues the Q/TC/DONE
// (and WRAPS) values expected to be visible before the next rising edge.
module tb_mod_counter_updown;

   typedef struct {
      string      tag;
      logic [3:0] q;
      logic       tc;
      logic       done;
      logic [1:0] wraps;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, ena, loadn, up, oneshot;
   logic [3:0] p;
   logic [3:0] q;
   logic       tc, done;
`ifdef WRAP_TALLY_EN
   logic [1:0] wraps;
`endif

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   mod_counter_updown #(
      .MODULE(10), .WIDTH(4)
`ifdef WRAP_TALLY_EN
     ,.WRAP_WIDTH(2)
`endif
   ) dut (
      .CLK(clk), .RST(rst), .CLK_ENA(ena), .LOADn(loadn), .UP(up),
      .ONESHOT(oneshot), .P(p), .Q(q), .TC(tc), .DONE(done)
`ifdef WRAP_TALLY_EN
     ,.WRAPS(wraps)
`endif
   );

   task automatic apply(input string tag, input logic r, input logic ld_n,
                        input logic en, input logic u, input logic os,
                        input logic [3:0] pv, input logic [3:0] eq,
                        input logic etc, input logic ed, input logic [1:0] ew);
      exp_t e;
      @(negedge clk);
      rst = r; loadn = ld_n; ena = en; up = u; oneshot = os; p = pv;
      e.tag = tag; e.q = eq; e.tc = etc; e.done = ed; e.wraps = ew;
      sb.push_back(e);
   endtask

   // Monitor: one observation per queued vector, between the edges.
   initial begin
      exp_t e;
      logic bad;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            bad = (q !== e.q) || (tc !== e.tc) || (done !== e.done);
`ifdef WRAP_TALLY_EN
            bad = bad || (wraps !== e.wraps);
`endif
            n_vec++;
            if (bad) begin
               n_miss++;
`ifdef WRAP_TALLY_EN
               $display("FAIL %s: got Q=%0d TC=%0b DONE=%0b WRAPS=%0d, want Q=%0d TC=%0b DONE=%0b WRAPS=%0d",
                        e.tag, q, tc, done, wraps, e.q, e.tc, e.done, e.wraps);
`else
               $display("FAIL %s: got Q=%0d TC=%0b DONE=%0b, want Q=%0d TC=%0b DONE=%0b",
                        e.tag, q, tc, done, e.q, e.tc, e.done);
`endif
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; loadn = 1'b1; ena = 1'b0; up = 1'b1; oneshot = 1'b0; p = '0;
      repeat (2) @(posedge clk);

      // Reset state
      apply("reset", 1, 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 2'd0);

      // 1: continuous up, 12 edges
      for (int i = 0; i < 12; i++)
         apply("t1_up", 0, 1, 1, 1, 0, 4'd0, 4'(i % 10), (i == 9), 0, (i > 9) ? 2'd1 : 2'd0);
      apply("t1_idle", 0, 1, 0, 1, 0, 4'd0, 4'd2, 0, 0, 2'd1);

      // 2: continuous down from P=2
      apply("t2_load", 0, 0, 0, 0, 0, 4'd2, 4'd2, 0, 0, 2'd1);
      apply("t2_dn2",  0, 1, 1, 0, 0, 4'd0, 4'd2, 0, 0, 2'd0);
      apply("t2_dn1",  0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 0, 2'd0);
      apply("t2_dn0",  0, 1, 1, 0, 0, 4'd0, 4'd0, 1, 0, 2'd0);
      apply("t2_dn9",  0, 1, 1, 0, 0, 4'd0, 4'd9, 0, 0, 2'd1);
      apply("t2_dn8",  0, 1, 0, 0, 0, 4'd0, 4'd8, 0, 0, 2'd1);

      // 3: one-shot up from P=7, halt, ONESHOT drop, reload
      apply("t3_load", 0, 0, 0, 1, 1, 4'd7, 4'd8, 0, 0, 2'd1);
      apply("t3_q7",   0, 1, 1, 1, 1, 4'd0, 4'd7, 0, 0, 2'd0);
      apply("t3_q8",   0, 1, 1, 1, 1, 4'd0, 4'd8, 0, 0, 2'd0);
      apply("t3_q9tc", 0, 1, 1, 1, 1, 4'd0, 4'd9, 1, 0, 2'd0);
      apply("t3_halt", 0, 1, 1, 1, 1, 4'd0, 4'd9, 0, 1, 2'd0);
      apply("t3_hold", 0, 1, 1, 1, 1, 4'd0, 4'd9, 0, 1, 2'd0);
      apply("t3_os0",  0, 1, 1, 1, 0, 4'd0, 4'd9, 0, 1, 2'd0);
      apply("t3_dn",   0, 1, 1, 0, 0, 4'd0, 4'd9, 0, 1, 2'd0);
      apply("t3_ld3",  0, 0, 1, 1, 0, 4'd3, 4'd9, 0, 1, 2'd0);
      apply("t3_q3",   0, 1, 0, 1, 0, 4'd0, 4'd3, 0, 0, 2'd0);

      // 4: clamp with enable high, then reset beats load
      apply("t4_clamp", 0, 0, 1, 1, 0, 4'd14, 4'd3, 0, 0, 2'd0);
      apply("t4_rstld", 1, 0, 1, 1, 0, 4'd5,  4'd9, 1, 0, 2'd0);
      apply("t4_rstq",  0, 1, 0, 1, 0, 4'd0,  4'd0, 0, 0, 2'd0);

      // 5: direction change at terminal value
      apply("t5_ld9",  0, 0, 0, 1, 0, 4'd9, 4'd0, 0, 0, 2'd0);
      apply("t5_tcup", 0, 0, 1, 1, 0, 4'd9, 4'd9, 1, 0, 2'd0);
      apply("t5_tcdn", 0, 1, 1, 0, 0, 4'd0, 4'd9, 0, 0, 2'd0);
      apply("t5_q8",   0, 1, 0, 0, 0, 4'd0, 4'd8, 0, 0, 2'd0);

      // Reset out of HALT, then counting resumes
      apply("th_ld8",  0, 0, 0, 1, 1, 4'd8, 4'd8, 0, 0, 2'd0);
      apply("th_q8",   0, 1, 1, 1, 1, 4'd0, 4'd8, 0, 0, 2'd0);
      apply("th_q9",   0, 1, 1, 1, 1, 4'd0, 4'd9, 1, 0, 2'd0);
      apply("th_rst",  1, 1, 1, 1, 1, 4'd0, 4'd9, 0, 1, 2'd0);
      apply("th_q0",   0, 1, 1, 1, 0, 4'd0, 4'd0, 0, 0, 2'd0);
      apply("th_q1",   0, 1, 0, 1, 0, 4'd0, 4'd1, 0, 0, 2'd0);

      // 6: five wraps saturate the tally, load clears it
      apply("t6_ld0", 0, 0, 0, 1, 0, 4'd0, 4'd1, 0, 0, 2'd0);
      for (int i = 0; i < 50; i++)
         apply("t6_wrap", 0, 1, 1, 1, 0, 4'd0, 4'(i % 10), ((i % 10) == 9), 0,
               (i / 10 > 3) ? 2'd3 : 2'(i / 10));
      apply("t6_sat",   0, 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 2'd3);
      apply("t6_clr",   0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 2'd3);
      apply("t6_clred", 0, 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 2'd0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d vectors unchecked, want 0", sb.size());
         n_miss++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
